id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline register with operand forwarding and load-use hazard detection. It sits directly upstream of the execute-stage ALU. Each cycle it latches one decoded instruction from ID, or holds, flushes, or inserts a bubble. It then drives the ALU's A, B and OPCODE inputs with operands forwarded from EX/MEM and MEM/WB.

## Interface
- No parameters. Data width is fixed at 32; register index width is fixed at 5.
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  5  source register indices.
- id_rdat1, id_rdat2  in  32  register-file read data for rs and rt.
- id_imm  in  32  extended immediate.
- id_shamt  in  5  shift amount.
- id_alusrc  in  1  1: operand B is the immediate.
- id_shift  in  1  1: shift form; A is rt and B is shamt.
- id_aluop  in  4  ALU opcode (0000 SLL … 1001 SLTU).
- id_wsel  in  5  destination register.
- id_regwen, id_memread, id_memwrite  in  1  control bits.
- stall  in  1  global freeze (memory wait).
- flush  in  1  squash the instruction entering EX (branch/jump resolve).
- exmem_regwen  in  1, exmem_wsel  in  5, exmem_result  in  32  EX/MEM writeback info.
- memwb_regwen  in  1, memwb_wsel  in  5, memwb_wdat  in  32  MEM/WB writeback info.
- alu_a, alu_b  out  32  ALU operands.
- alu_op  out  4  ALU opcode.
- ex_valid, ex_regwen, ex_memread, ex_memwrite  out  1  registered control bits.
- ex_wsel  out  5  registered destination register.
- ex_store_data  out  32  forwarded rt value, used for stores.
- hazard_stall  out  1  tells PC and IF/ID to hold (load-use).

## Operation
- The EX register holds: valid, rs, rt, rdat1, rdat2, imm, shamt, alusrc, shift, aluop, wsel, regwen, memread, memwrite.
- Register update priority, evaluated on each rising edge:
  1. flush → load a bubble.
  2. stall → hold.
  3. hazard_stall → load a bubble.
  4. Otherwise → load the ID fields.
- Bubble: valid, regwen, memread and memwrite are all 0. Other fields are don't-care; the implementation zeroes them.
- Load-use detection is combinational. Raw hazard = ex_valid & ex_memread & ex_wsel≠0 & id_valid & (ex_wsel==id_rs | ex_wsel==id_rt).
- hazard_stall = raw hazard & ~flush. Stall does not gate hazard_stall, because the upstream stages freeze anyway.
- Forwarding is combinational and operates on the registered rs and rt. It is applied separately for each source:
  - EX/MEM match (exmem_regwen & exmem_wsel≠0 & exmem_wsel==src) → exmem_result.
  - Else MEM/WB match (same test using memwb_*) → memwb_wdat.
  - Else the registered rdat.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- Operand selection, where fwd_rs and fwd_rt are the forwarded values:
  - shift=1: alu_a = fwd_rt, alu_b = {27'b0, shamt}.
  - Else: alu_a = fwd_rs, and alu_b = alusrc ? imm : fwd_rt.
- alu_op = registered aluop. ex_store_data = fwd_rt always.
- A load result reaches its dependent only through the MEM/WB path, after exactly one bubble. EX/MEM never forwards load data.

## Timing
- Latency is one cycle: ID fields at edge N appear on the EX outputs after edge N.
- Forwarding and operand muxing add no cycle. alu_a and alu_b are valid combinationally within the same cycle.
- Reset (nRST low, asynchronous) clears every register to 0. All outputs are then 0: alu_a, alu_b, alu_op, ex_* and ex_store_data. hazard_stall is 0, because ex_valid is 0.
- Reset released mid-stream: the first edge with nRST high loads ID normally.
- A load-use hazard produces exactly one bubble cycle. On the next edge the load has left EX and hazard_stall deasserts.
- Simultaneous events:
  - flush & stall: flush wins and a bubble is loaded.
  - stall held for many cycles: the EX contents and outputs are held. Forwarded values track the live EX/MEM and MEM/WB inputs.
  - A dependency on both EX/MEM and MEM/WB for the same register takes the EX/MEM value.

## Test plan
- Reset: with nRST low, all outputs are 0 and hazard_stall is 0. Release, then ID presents add rs=1 (rdat1=5), rt=2 (rdat2=7), aluop=0110 → next cycle alu_a=5, alu_b=7, alu_op=0110, ex_valid=1.
- Forwarding: EX holds rs=3 with rdat1=1; exmem wsel=3, regwen=1, result=0x10; memwb wsel=3, wdat=0x20 → alu_a=0x10. Drop exmem_regwen → alu_a=0x20. Set wsel=0 on both → alu_a=1.
- Load-use: EX holds lw to $4 (memread=1); ID uses rs=4 → hazard_stall=1 and the next EX contents are a bubble (ex_valid=0). The following cycle hazard_stall=0, the dependent enters EX, and memwb wdat=0xABCD gives alu_a=0xABCD.
- Flush beats stall: with flush=1 and stall=1 together → after the edge ex_valid=0 and ex_regwen=0. With stall=1 alone for 3 cycles → EX outputs unchanged.
- Shift and immediate forms: shift=1, rt=5 forwarded from memwb 0x8, shamt=2 → alu_a=0x8, alu_b=2, alu_op=0000. alusrc=1, imm=0xFFFFFFFC → alu_b=0xFFFFFFFC, with ex_store_data still carrying fwd_rt.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the execute-stage ALU.
// Holds one decoded instruction, can freeze, flush or bubble, forwards
// operands from EX/MEM and MEM/WB, and flags load-use hazards upstream.
//
// Valid semantics: id_valid marks a real instruction on the ID fields and
// is sampled on every rising edge that is not flushed, stalled or hazarded;
// ex_valid marks a real instruction in EX. There is no ready signal: stall
// (global freeze) and hazard_stall (load-use hold of PC and IF/ID) are the
// only back-pressure, and flush squashes whatever would enter EX.
module id_ex_stage (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [31:0] id_rdat1,
  input  logic [31:0] id_rdat2,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_shamt,
  input  logic        id_alusrc,
  input  logic        id_shift,
  input  logic [3:0]  id_aluop,
  input  logic [4:0]  id_wsel,
  input  logic        id_regwen,
  input  logic        id_memread,
  input  logic        id_memwrite,
  input  logic        stall,
  input  logic        flush,
  input  logic        exmem_regwen,
  input  logic [4:0]  exmem_wsel,
  input  logic [31:0] exmem_result,
  input  logic        memwb_regwen,
  input  logic [4:0]  memwb_wsel,
  input  logic [31:0] memwb_wdat,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  output logic        ex_valid,
  output logic        ex_regwen,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic [4:0]  ex_wsel,
  output logic [31:0] ex_store_data,
  output logic        hazard_stall
);

  logic        valid_q,    valid_d;
  logic [4:0]  rs_q,       rs_d;
  logic [4:0]  rt_q,       rt_d;
  logic [31:0] rdat1_q,    rdat1_d;
  logic [31:0] rdat2_q,    rdat2_d;
  logic [31:0] imm_q,      imm_d;
  logic [4:0]  shamt_q,    shamt_d;
  logic        alusrc_q,   alusrc_d;
  logic        shift_q,    shift_d;
  logic [3:0]  aluop_q,    aluop_d;
  logic [4:0]  wsel_q,     wsel_d;
  logic        regwen_q,   regwen_d;
  logic        memread_q,  memread_d;
  logic        memwrite_q, memwrite_d;

  logic        raw_hazard;
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;

  // Load-use detection: a load in EX whose destination an ID source needs.
  always_comb begin
    raw_hazard = valid_q && memread_q && (wsel_q != 5'd0) && id_valid &&
                 ((wsel_q == id_rs) || (wsel_q == id_rt));
    // Flush discards the dependent anyway, so no hold is needed then.
    hazard_stall = raw_hazard && !flush;
  end

  // Next-state selection: flush > stall > load-use bubble > load from ID.
  always_comb begin
    valid_d    = valid_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rdat1_d    = rdat1_q;
    rdat2_d    = rdat2_q;
    imm_d      = imm_q;
    shamt_d    = shamt_q;
    alusrc_d   = alusrc_q;
    shift_d    = shift_q;
    aluop_d    = aluop_q;
    wsel_d     = wsel_q;
    regwen_d   = regwen_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    if (flush || (!stall && raw_hazard)) begin
      // Bubble: everything zeroed so it can never match a forward.
      valid_d    = 1'b0;
      rs_d       = 5'd0;
      rt_d       = 5'd0;
      rdat1_d    = 32'd0;
      rdat2_d    = 32'd0;
      imm_d      = 32'd0;
      shamt_d    = 5'd0;
      alusrc_d   = 1'b0;
      shift_d    = 1'b0;
      aluop_d    = 4'd0;
      wsel_d     = 5'd0;
      regwen_d   = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
    end else if (!stall) begin
      valid_d    = id_valid;
      rs_d       = id_rs;
      rt_d       = id_rt;
      rdat1_d    = id_rdat1;
      rdat2_d    = id_rdat2;
      imm_d      = id_imm;
      shamt_d    = id_shamt;
      alusrc_d   = id_alusrc;
      shift_d    = id_shift;
      aluop_d    = id_aluop;
      wsel_d     = id_wsel;
      regwen_d   = id_regwen;
      memread_d  = id_memread;
      memwrite_d = id_memwrite;
    end
  end

  // EX register; asynchronous reset clears every field.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q    <= 1'b0;
      rs_q       <= 5'd0;
      rt_q       <= 5'd0;
      rdat1_q    <= 32'd0;
      rdat2_q    <= 32'd0;
      imm_q      <= 32'd0;
      shamt_q    <= 5'd0;
      alusrc_q   <= 1'b0;
      shift_q    <= 1'b0;
      aluop_q    <= 4'd0;
      wsel_q     <= 5'd0;
      regwen_q   <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rdat1_q    <= rdat1_d;
      rdat2_q    <= rdat2_d;
      imm_q      <= imm_d;
      shamt_q    <= shamt_d;
      alusrc_q   <= alusrc_d;
      shift_q    <= shift_d;
      aluop_q    <= aluop_d;
      wsel_q     <= wsel_d;
      regwen_q   <= regwen_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
    end
  end

  // Forwarding per source: EX/MEM beats MEM/WB; register 0 never forwards.
  always_comb begin
    fwd_rs = rdat1_q;
    fwd_rt = rdat2_q;
    if (exmem_regwen && (exmem_wsel != 5'd0) && (exmem_wsel == rs_q)) begin
      fwd_rs = exmem_result;
    end else if (memwb_regwen && (memwb_wsel != 5'd0) && (memwb_wsel == rs_q)) begin
      fwd_rs = memwb_wdat;
    end
    if (exmem_regwen && (exmem_wsel != 5'd0) && (exmem_wsel == rt_q)) begin
      fwd_rt = exmem_result;
    end else if (memwb_regwen && (memwb_wsel != 5'd0) && (memwb_wsel == rt_q)) begin
      fwd_rt = memwb_wdat;
    end
  end

  // Operand muxing: shift form uses rt as A and shamt as B.
  always_comb begin
    alu_a = fwd_rs;
    alu_b = alusrc_q ? imm_q : fwd_rt;
    if (shift_q) begin
      alu_a = fwd_rt;
      alu_b = {27'd0, shamt_q};
    end
  end

  assign alu_op        = aluop_q;
  assign ex_valid      = valid_q;
  assign ex_regwen     = regwen_q;
  assign ex_memread    = memread_q;
  assign ex_memwrite   = memwrite_q;
  assign ex_wsel       = wsel_q;
  assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors for id_ex_stage. The driver pushes the
// hand-computed expected EX view into a queue; a monitor on the falling
// edge pops and compares.
module tb_id_ex_stage;

  typedef struct packed {
    logic [7:0]  tag;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        v;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [4:0]  wsel;
    logic [31:0] sd;
    logic        hz;
  } exp_t;

  localparam int W = $bits(exp_t);

  logic        CLK, nRST;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt;
  logic [31:0] id_rdat1, id_rdat2, id_imm;
  logic [4:0]  id_shamt;
  logic        id_alusrc, id_shift;
  logic [3:0]  id_aluop;
  logic [4:0]  id_wsel;
  logic        id_regwen, id_memread, id_memwrite;
  logic        stall, flush;
  logic        exmem_regwen;
  logic [4:0]  exmem_wsel;
  logic [31:0] exmem_result;
  logic        memwb_regwen;
  logic [4:0]  memwb_wsel;
  logic [31:0] memwb_wdat;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic        ex_valid, ex_regwen, ex_memread, ex_memwrite;
  logic [4:0]  ex_wsel;
  logic [31:0] ex_store_data;
  logic        hazard_stall;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fails  = 0;
  int n_tag    = 0;

  id_ex_stage dut (
    .CLK(CLK), .nRST(nRST),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rdat1(id_rdat1), .id_rdat2(id_rdat2), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_alusrc(id_alusrc), .id_shift(id_shift),
    .id_aluop(id_aluop), .id_wsel(id_wsel), .id_regwen(id_regwen),
    .id_memread(id_memread), .id_memwrite(id_memwrite),
    .stall(stall), .flush(flush),
    .exmem_regwen(exmem_regwen), .exmem_wsel(exmem_wsel), .exmem_result(exmem_result),
    .memwb_regwen(memwb_regwen), .memwb_wsel(memwb_wsel), .memwb_wdat(memwb_wdat),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .ex_valid(ex_valid), .ex_regwen(ex_regwen), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_wsel(ex_wsel),
    .ex_store_data(ex_store_data), .hazard_stall(hazard_stall)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  // Monitor / scoreboard
  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      exp_t e, act;
      e = exp_t'(exp_q.pop_front());
      act = '{tag: e.tag, a: alu_a, b: alu_b, op: alu_op, v: ex_valid,
              rw: ex_regwen, mr: ex_memread, mw: ex_memwrite, wsel: ex_wsel,
              sd: ex_store_data, hz: hazard_stall};
      n_checks++;
      if (act !== e) begin
        n_fails++;
        $display("FAIL chk%0d: got a=%h b=%h op=%h v=%b rw=%b mr=%b mw=%b wsel=%0d sd=%h hz=%b; want a=%h b=%h op=%h v=%b rw=%b mr=%b mw=%b wsel=%0d sd=%h hz=%b",
                 e.tag, act.a, act.b, act.op, act.v, act.rw, act.mr, act.mw, act.wsel, act.sd, act.hz,
                 e.a, e.b, e.op, e.v, e.rw, e.mr, e.mw, e.wsel, e.sd, e.hz);
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_ex(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                           input logic v, input logic rw, input logic mr, input logic mw,
                           input logic [4:0] wsel, input logic [31:0] sd, input logic hz);
    exp_t e;
    n_tag++;
    e = '{tag: n_tag[7:0], a: a, b: b, op: op, v: v, rw: rw, mr: mr, mw: mw,
          wsel: wsel, sd: sd, hz: hz};
    exp_q.push_back(W'(e));
    @(negedge CLK);
    #1;
  endtask

  task automatic expect_zero();
    expect_ex(32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [31:0] d1,
                        input logic [4:0] rt, input logic [31:0] d2, input logic [31:0] imm,
                        input logic [4:0] shamt, input logic alusrc, input logic shift,
                        input logic [3:0] aluop, input logic [4:0] wsel, input logic regwen,
                        input logic memread, input logic memwrite);
    id_valid = v;  id_rs = rs;  id_rdat1 = d1;  id_rt = rt;  id_rdat2 = d2;
    id_imm = imm;  id_shamt = shamt;  id_alusrc = alusrc;  id_shift = shift;
    id_aluop = aluop;  id_wsel = wsel;  id_regwen = regwen;
    id_memread = memread;  id_memwrite = memwrite;
  endtask

  task automatic clr_fwd();
    exmem_regwen = 1'b0; exmem_wsel = 5'd0; exmem_result = 32'd0;
    memwb_regwen = 1'b0; memwb_wsel = 5'd0; memwb_wdat   = 32'd0;
  endtask

  // Directed stimulus
  initial begin
    nRST = 1'b0; stall = 1'b0; flush = 1'b0;
    clr_fwd();
    // add r9 = r1 + r2, presented while reset is held
    set_id(1, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 5'd0, 0, 0, 4'b0110, 5'd9, 1, 0, 0);
    expect_zero();
    expect_zero();

    nRST = 1'b1;
    tick();
    expect_ex(32'd5, 32'd7, 4'b0110, 1, 1, 0, 0, 5'd9, 32'd7, 0);

    // Forwarding on rs=3 / rt=6
    set_id(1, 5'd3, 32'd1, 5'd6, 32'h33, 32'd0, 5'd0, 0, 0, 4'b0110, 5'd10, 1, 0, 0);
    tick();
    exmem_regwen = 1; exmem_wsel = 5'd3; exmem_result = 32'h10;
    memwb_regwen = 1; memwb_wsel = 5'd3; memwb_wdat   = 32'h20;
    expect_ex(32'h10, 32'h33, 4'b0110, 1, 1, 0, 0, 5'd10, 32'h33, 0);
    stall = 1'b1;
    exmem_regwen = 0;
    expect_ex(32'h20, 32'h33, 4'b0110, 1, 1, 0, 0, 5'd10, 32'h33, 0);
    exmem_regwen = 1; exmem_wsel = 5'd0; memwb_wsel = 5'd0;
    expect_ex(32'h1, 32'h33, 4'b0110, 1, 1, 0, 0, 5'd10, 32'h33, 0);
    exmem_wsel = 5'd6; exmem_result = 32'h77; memwb_wsel = 5'd6; memwb_wdat = 32'h66;
    expect_ex(32'h1, 32'h77, 4'b0110, 1, 1, 0, 0, 5'd10, 32'h77, 0);

    // Load-use: lw r4, 4(r0) then a user of r4
    stall = 1'b0;
    clr_fwd();
    set_id(1, 5'd0, 32'h100, 5'd0, 32'd0, 32'd4, 5'd0, 1, 0, 4'b0110, 5'd4, 1, 1, 0);
    tick();
    set_id(1, 5'd4, 32'd0, 5'd7, 32'h70, 32'd0, 5'd0, 0, 0, 4'b0110, 5'd8, 1, 0, 0);
    expect_ex(32'h100, 32'd4, 4'b0110, 1, 1, 1, 0, 5'd4, 32'd0, 1);
    tick();
    exmem_regwen = 1; exmem_wsel = 5'd4; exmem_result = 32'h104;
    expect_zero();
    tick();
    exmem_regwen = 0; exmem_wsel = 5'd0; exmem_result = 32'd0;
    memwb_regwen = 1; memwb_wsel = 5'd4; memwb_wdat = 32'hABCD;
    expect_ex(32'hABCD, 32'h70, 4'b0110, 1, 1, 0, 0, 5'd8, 32'h70, 0);

    // Flush beats stall
    clr_fwd();
    flush = 1'b1; stall = 1'b1;
    tick();
    expect_zero();

    // Stall holds EX for three edges while ID changes
    flush = 1'b0; stall = 1'b0;
    set_id(1, 5'd1, 32'h11, 5'd2, 32'h22, 32'd0, 5'd0, 0, 0, 4'b1001, 5'd3, 1, 0, 1);
    tick();
    expect_ex(32'h11, 32'h22, 4'b1001, 1, 1, 0, 1, 5'd3, 32'h22, 0);
    stall = 1'b1;
    set_id(1, 5'd5, 32'h55, 5'd6, 32'h66, 32'd0, 5'd0, 0, 0, 4'b0011, 5'd1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      expect_ex(32'h11, 32'h22, 4'b1001, 1, 1, 0, 1, 5'd3, 32'h22, 0);
    end

    // Flush suppresses hazard_stall
    stall = 1'b0;
    set_id(1, 5'd0, 32'h200, 5'd0, 32'd0, 32'd8, 5'd0, 1, 0, 4'b0110, 5'd4, 1, 1, 0);
    tick();
    set_id(1, 5'd0, 32'd0, 5'd4, 32'd0, 32'd0, 5'd0, 0, 0, 4'b0110, 5'd8, 1, 0, 0);
    flush = 1'b1;
    expect_ex(32'h200, 32'd8, 4'b0110, 1, 1, 1, 0, 5'd4, 32'd0, 0);
    flush = 1'b0;
    expect_zero();

    // Shift form: rt=5 forwarded from MEM/WB
    set_id(1, 5'd9, 32'h99, 5'd5, 32'h1, 32'd0, 5'd2, 0, 1, 4'b0000, 5'd7, 1, 0, 0);
    tick();
    memwb_regwen = 1; memwb_wsel = 5'd5; memwb_wdat = 32'h8;
    expect_ex(32'h8, 32'd2, 4'b0000, 1, 1, 0, 0, 5'd7, 32'h8, 0);

    // Immediate form; store data still carries forwarded rt
    set_id(1, 5'd1, 32'h40, 5'd5, 32'h3, 32'hFFFF_FFFC, 5'd0, 1, 0, 4'b0110, 5'd2, 1, 0, 0);
    tick();
    expect_ex(32'h40, 32'hFFFF_FFFC, 4'b0110, 1, 1, 0, 0, 5'd2, 32'h8, 0);

    // Reset mid-stream, then the first edge after release loads ID
    clr_fwd();
    nRST = 1'b0;
    expect_zero();
    nRST = 1'b1;
    tick();
    expect_ex(32'h40, 32'hFFFF_FFFC, 4'b0110, 1, 1, 0, 0, 5'd2, 32'h3, 0);

    repeat (2) @(negedge CLK);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
